// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee vending controller: FSM states, product
// codes and the price table.
package coffee_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_BREW    = 2'd2,
    ST_PAYOUT  = 2'd3
  } state_t;

  localparam int unsigned EXPRESSO    = 0;
  localparam int unsigned COFFEE_MILK = 1;
  localparam int unsigned CAPUCCINO   = 2;
  localparam int unsigned MOCACCINO   = 3;

  localparam int unsigned PRICE_W = 3;

  // Prices in coin units; the caller zero-extends to its credit width.
  function automatic logic [PRICE_W-1:0] price_of(input int unsigned code);
    case (code)
      EXPRESSO:    price_of = 3'd3;
      COFFEE_MILK: price_of = 3'd4;
      CAPUCCINO:   price_of = 3'd5;
      MOCACCINO:   price_of = 3'd7;
      default:     price_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/coffee_vend_ctrl_brew_timer.sv
// Loadable down-counter that times the brew phase; zero flags the last cycle.
module brew_timer #(
  parameter int unsigned CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic zero
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(CYCLES - 1);
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/coffee_vend_ctrl.sv
// Coffee vending controller: coin credit accumulation, selection validation,
// brew timing and change presentation through a valid/ack handshake.
module coffee_vend_ctrl
  import coffee_pkg::*;
#(
  parameter int unsigned COIN_W      = 4,
  parameter int unsigned TYPE_W      = 3,
  parameter int unsigned N_TYPES     = 4,
  parameter int unsigned BREW_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coin_i,
  input  logic [TYPE_W-1:0] type_i,
  input  logic              select_i,
  input  logic              cancel_i,
  input  logic              change_ack_i,
  output logic [COIN_W-1:0] credit_o,
  output logic [COIN_W-1:0] change_o,
  output logic              change_valid_o,
  output logic              brewing_o,
  output logic              insufficient_o,
  output logic              type_err_o,
  output logic              coin_reject_o
);

  localparam logic [COIN_W-1:0] CREDIT_MAX = '1;

  state_t            state, state_nxt;
  logic [COIN_W-1:0] credit, credit_nxt;
  logic [COIN_W-1:0] change, change_nxt;
  logic              insufficient, insufficient_nxt;
  logic              type_err, type_err_nxt;
  logic              coin_reject, coin_reject_nxt;
  logic              tmr_load, tmr_zero, tmr_count;

  logic              type_valid;
  logic [COIN_W-1:0] price;
  logic              afford;

  assign type_valid = (32'(type_i) < 32'(N_TYPES));
  assign price      = COIN_W'(price_of(32'(type_i)));
  assign afford     = (credit >= price);

  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    change_nxt       = change;
    insufficient_nxt = 1'b0;
    type_err_nxt     = 1'b0;
    coin_reject_nxt  = 1'b0;
    tmr_load         = 1'b0;

    case (state)
      ST_IDLE, ST_COLLECT: begin
        if ((state == ST_COLLECT) && cancel_i) begin
          change_nxt      = credit;
          credit_nxt      = '0;
          state_nxt       = ST_PAYOUT;
          coin_reject_nxt = coin_i;
        end else if (select_i && type_valid && afford && (state == ST_COLLECT)) begin
          change_nxt      = credit - price;
          credit_nxt      = '0;
          state_nxt       = ST_BREW;
          tmr_load        = 1'b1;
          coin_reject_nxt = coin_i;
        end else begin
          // A failed select still lets a same-cycle coin through.
          if (select_i) begin
            type_err_nxt     = !type_valid;
            insufficient_nxt = type_valid;
          end
          if (coin_i) begin
            if (credit == CREDIT_MAX) begin
              coin_reject_nxt = 1'b1;
            end else begin
              credit_nxt = credit + COIN_W'(1);
              state_nxt  = ST_COLLECT;
            end
          end
        end
      end
      ST_BREW: begin
        coin_reject_nxt = coin_i;
        if (tmr_zero) begin
          state_nxt = ST_PAYOUT;
        end
      end
      ST_PAYOUT: begin
        coin_reject_nxt = coin_i;
        if (change_ack_i) begin
          state_nxt  = ST_IDLE;
          change_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      credit       <= '0;
      change       <= '0;
      insufficient <= 1'b0;
      type_err     <= 1'b0;
      coin_reject  <= 1'b0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      change       <= change_nxt;
      insufficient <= insufficient_nxt;
      type_err     <= type_err_nxt;
      coin_reject  <= coin_reject_nxt;
    end
  end

  // Timer holds at zero once expired; the FSM leaves BREW on that cycle.
  assign tmr_count = (state == ST_BREW) && !tmr_zero;

  brew_timer #(
    .CYCLES(BREW_CYCLES)
  ) u_brew_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .count(tmr_count),
    .zero (tmr_zero)
  );

  assign credit_o       = credit;
  assign change_o       = change;
  assign change_valid_o = (state == ST_PAYOUT);
  assign brewing_o      = (state == ST_BREW);
  assign insufficient_o = insufficient;
  assign type_err_o     = type_err;
  assign coin_reject_o  = coin_reject;

endmodule
